// File: rtl/fifo_packet_reader.sv
// Drains length-prefixed packets from a first-word-fall-through FIFO and
// presents the payload as a valid/ready stream through a 2-entry buffer.
module fifo_packet_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_rvalid,
  output logic                  fifo_ren,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  zero_len,
  output logic [31:0]           pkt_count
);

  typedef enum logic {HDR, PAY} state_t;

  state_t                state;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [1:0]            buf_count;
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [1:0]            buf_last;

  logic                  push;
  logic                  pop;
  logic                  wr_idx;
  logic [LEN_WIDTH-1:0]  hdr_len;

  assign hdr_len = fifo_rdata[LEN_WIDTH-1:0];

  // Only registered state gates the pop, so m_tready never reaches fifo_ren.
  assign fifo_ren = !rst && fifo_rvalid && ((state == HDR) || (buf_count != 2'd2));
  assign push     = fifo_ren && (state == PAY);
  assign pop      = m_tvalid && m_tready;

  // A same-cycle pop shifts the tail down, so the new word lands one slot lower.
  assign wr_idx   = pop ? (buf_count == 2'd2) : (buf_count == 2'd1);

  assign m_tvalid = (buf_count != 2'd0);
  assign m_tdata  = buf_data[0];
  assign m_tlast  = buf_last[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HDR;
      remaining   <= '0;
      buf_count   <= 2'd0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_last    <= 2'b00;
      zero_len    <= 1'b0;
      pkt_count   <= 32'd0;
    end else begin
      if (fifo_ren) begin
        unique case (state)
          HDR: begin
            if (hdr_len == '0) begin
              zero_len <= 1'b1;
            end else begin
              remaining <= hdr_len;
              state     <= PAY;
            end
          end
          PAY: begin
            remaining <= remaining - 1'b1;
            if (remaining == LEN_WIDTH'(1)) state <= HDR;
          end
          default: state <= HDR;
        endcase
      end

      if (pop) begin
        buf_data[0] <= buf_data[1];
        buf_last[0] <= buf_last[1];
        if (m_tlast) pkt_count <= pkt_count + 32'd1;
      end

      if (push) begin
        buf_data[wr_idx] <= fifo_rdata;
        buf_last[wr_idx] <= (remaining == LEN_WIDTH'(1));
      end

      unique case ({push, pop})
        2'b10:   buf_count <= buf_count + 2'd1;
        2'b01:   buf_count <= buf_count - 2'd1;
        default: buf_count <= buf_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_packet_reader.sv
// Randomized scoreboard bench for fifo_packet_reader against a queue-based
// FIFO and packet-expansion model.
module tb_fifo_packet_reader;

  typedef struct packed {
    logic        l;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fifo_rdata;
  logic        fifo_rvalid;
  logic        fifo_ren;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        zero_len;
  logic [31:0] pkt_count;

  fifo_packet_reader #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .fifo_rdata(fifo_rdata), .fifo_rvalid(fifo_rvalid), .fifo_ren(fifo_ren),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .zero_len(zero_len), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  logic [31:0] fifo_q [$];
  exp_t        exp_q [$];
  int          pop_cyc [$];
  int          xfer_cyc [$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc = 0;
  int          pop_count = 0;
  int          xfer_count = 0;
  int          exp_pkt = 0;
  bit          exp_zero = 0;
  int          ready_mode = 1;  // 0 low, 1 high, 2 random
  int          gate_mode = 0;   // 0 always, 1 toggle, 2 random
  bit          gate = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Packet model: header, then N payload words; each payload word is expected
  // on the stream in order, with last on the N-th.
  task automatic send(input logic [31:0] hdr, input logic [31:0] base, input bit rnd);
    int n;
    logic [31:0] w;
    n = int'(hdr[15:0]);
    fifo_q.push_back(hdr);
    if (n == 0) exp_zero = 1;
    for (int i = 0; i < n; i++) begin
      w = rnd ? $urandom : base + i;
      fifo_q.push_back(w);
      exp_q.push_back({(i == n - 1), w});
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) begin
      total_cnt++;
      $display("FAIL drain_timeout: %0d words left, %0d expected outputs left", fifo_q.size(), exp_q.size());
      fifo_q.delete();
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : cycle_counter
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // FIFO model with first-word-fall-through read port.
  initial begin : fifo_model
    bit ren_s;
    forever begin
      @(negedge clk);
      ren_s = fifo_ren;
      if (!fifo_rvalid) check("ren_without_rvalid", fifo_ren, 0);
      if (ren_s) begin
        pop_count++;
        pop_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      if (ren_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
      case (gate_mode)
        0:       gate = 1;
        1:       gate = ~gate;
        default: gate = $urandom_range(0, 1);
      endcase
      case (ready_mode)
        0:       m_tready = 0;
        1:       m_tready = 1;
        default: m_tready = ($urandom_range(0, 3) != 0);
      endcase
      fifo_rvalid = gate && (fifo_q.size() != 0);
      fifo_rdata  = fifo_rvalid ? fifo_q[0] : $urandom;
    end
  end

  initial begin : monitor
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    exp_t        e;
    prev_stall = 0;
    prev_data  = 0;
    prev_last  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall)
          check("hold_stable", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_last, prev_data});
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL extra_xfer: got data %0h last %0b, expected no output", m_tdata, m_tlast);
          end else begin
            e = exp_q.pop_front();
            check("xfer", {m_tlast, m_tdata}, {e.l, e.d});
            $display("xfer data=%08h last=%0b cycle=%0d", m_tdata, m_tlast, cyc);
            if (e.l) exp_pkt++;
            xfer_count++;
            xfer_cyc.push_back(cyc);
          end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
      end
    end
  end

  initial begin : stimulus
    int pop0;
    int start;
    int k;
    rst = 1; fifo_rvalid = 0; fifo_rdata = 0; m_tready = 0;
    repeat (2) @(posedge clk);

    // Single packet, loaded while reset is still held.
    pop0 = pop_count;
    pop_cyc.delete();
    xfer_cyc.delete();
    send(32'h3, 32'hA, 0);
    repeat (2) @(negedge clk);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_zero_len", zero_len, 0);
    check("rst_rvalid_seen", fifo_rvalid, 1);
    check("rst_ren", fifo_ren, 0);
    @(posedge clk);
    #2 rst = 0;
    wait_drain();
    check("t1_pops", pop_count - pop0, 4);
    check("t1_xfers", xfer_cyc.size(), 3);
    if (xfer_cyc.size() >= 3 && pop_cyc.size() >= 1) begin
      check("t1_latency", xfer_cyc[0] - pop_cyc[0], 2);
      check("t1_burst", xfer_cyc[2] - xfer_cyc[0], 2);
    end
    check("t1_pkt_count", pkt_count, exp_pkt);

    // Back-pressure.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    pop0 = pop_count;
    send(32'h4, 32'h1, 0);
    repeat (12) @(negedge clk);
    check("bp_pops", pop_count - pop0, 3);
    check("bp_tvalid", m_tvalid, 1);
    check("bp_tdata", m_tdata, 1);
    ready_mode = 1;
    wait_drain();
    check("bp_pkt_count", pkt_count, exp_pkt);

    // Zero-length header and header upper-bit masking.
    send(32'h0, 32'h0, 0);
    send(32'hFFFF_0001, 32'h55, 0);
    wait_drain();
    check("zl_zero_len", zero_len, 1);
    check("zl_pkt_count", pkt_count, exp_pkt);

    // Starved FIFO.
    gate_mode = 1;
    send(32'h5, 32'h100, 0);
    wait_drain();
    gate_mode = 0;
    check("starve_pkt_count", pkt_count, exp_pkt);

    // Back-to-back packets.
    send(32'h1, 32'h200, 0);
    send(32'h2, 32'h300, 0);
    send(32'h1, 32'h400, 0);
    wait_drain();
    check("b2b_pkt_count", pkt_count, exp_pkt);

    // Reset mid-packet after two of six payload words.
    start = xfer_count;
    send(32'h6, 32'h500, 0);
    k = 0;
    while (xfer_count < start + 2 && k < 200) begin
      @(posedge clk);
      k++;
    end
    check("mid_rst_reached", xfer_count - start, 2);
    #2;
    rst = 1;
    fifo_q.delete();
    exp_q.delete();
    exp_pkt = 0;
    exp_zero = 0;
    @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
    check("mid_rst_tvalid", m_tvalid, 0);
    check("mid_rst_tlast", m_tlast, 0);
    check("mid_rst_tdata", m_tdata, 0);
    check("mid_rst_pkt_count", pkt_count, 0);
    check("mid_rst_zero_len", zero_len, 0);
    send(32'h2, 32'h600, 0);
    wait_drain();
    check("post_rst_pkt_count", pkt_count, exp_pkt);

    // Randomized traffic with random back-pressure and starvation.
    gate_mode = 2;
    ready_mode = 2;
    for (int p = 0; p < 30; p++) begin
      logic [31:0] hdr;
      hdr = {16'($urandom), 16'($urandom_range(0, 5))};
      send(hdr, 32'h0, 1);
    end
    wait_drain();
    check("rand_pkt_count", pkt_count, exp_pkt);
    check("rand_zero_len", zero_len, exp_zero);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_packet_reader.md
# fifo_packet_reader

Read-side companion to the team's `fifo` block (first-word-fall-through read port: `rdata`/`rvalid`/`ren`).
- Drains length-prefixed packets from the FIFO and presents payload as a valid/ready stream with `m_tlast` on the final word.
- Registers all data through a 2-entry output buffer, so downstream never sees FIFO output while `rvalid` is low.
- `fifo_ren` has no combinational dependence on `m_tready`.

## Interface

Parameters:
- DATA_WIDTH, 32, FIFO word and stream data width (must be ≤ 72 and ≥ LEN_WIDTH).
- LEN_WIDTH, 16, width of the payload-length field in the header word.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- fifo_rdata  in  DATA_WIDTH  FIFO read data; valid only while fifo_rvalid=1.
- fifo_rvalid  in  1  FIFO non-empty.
- fifo_ren  out  1  pop FIFO head this cycle.
- m_tdata  out  DATA_WIDTH  payload word.
- m_tvalid  out  1  m_tdata valid.
- m_tready  in  1  downstream accepts.
- m_tlast  out  1  final payload word of packet.
- zero_len  out  1  sticky: a header with length 0 was consumed.
- pkt_count  out  32  packets fully delivered (wraps).

## Operation

- Packet format: one header word, then N payload words.
  - N = header[LEN_WIDTH-1:0].
  - Header bits above LEN_WIDTH are ignored.
  - The header itself is never output.
- FSM states:
  - HDR (reset state): fifo_ren = fifo_rvalid.
    - On pop with N≠0: remaining ← N, go to PAY.
    - On pop with N=0: set zero_len, stay in HDR (no output).
  - PAY: fifo_ren = fifo_rvalid && (buf_count < 2). Each pop writes {fifo_rdata, last=(remaining==1)} into the buffer and decrements remaining. The pop with remaining==1 returns to HDR.
- fifo_ren is never asserted while fifo_rvalid=0, so the FIFO never sees a read error.
- Output buffer:
  - 2 entries, FIFO order, buf_count in 0..2.
  - m_tvalid = (buf_count ≠ 0); head entry drives m_tdata/m_tlast.
  - Transfer occurs when m_tvalid && m_tready.
  - Push and pop in the same cycle leave buf_count unchanged.
- m_tdata/m_tlast are held stable while m_tvalid && !m_tready.
- pkt_count increments by 1 on each transfer with m_tlast=1; it wraps 2^32-1 → 0.
- remaining is LEN_WIDTH bits; maximum packet is 2^LEN_WIDTH-1 payload words.
- A header may be popped in HDR even when buf_count=2; headers do not consume buffer space.

## Timing

- Reset values:
  - state=HDR, remaining=0, buf_count=0.
  - fifo_ren=0 while rst=1; m_tvalid=0, m_tlast=0, m_tdata=0.
  - zero_len=0, pkt_count=0.
- Reset mid-packet discards buffered words and the remaining count. The first FIFO word after reset is treated as a header.
- Latency:
  - Header popped at cycle t → earliest payload pop at t+1.
  - A payload word popped at cycle t appears on m_tdata at t+1.
  - Header-to-first-output is 2 cycles.
- Throughput: 1 payload word/cycle sustained with m_tready=1 and fifo_rvalid=1 (buf_count stays at 1). Each header costs 1 bubble cycle.
- Back-pressure: with m_tready=0, at most 2 words are popped before fifo_ren drops. fifo_ren reasserts the cycle after buf_count falls below 2.
- fifo_rvalid dropping mid-packet: no pop and no decrement; the FSM waits in PAY indefinitely.
- The last payload pop and the next header pop occur in consecutive cycles at the earliest, never in the same cycle.

## Test plan

- Single packet: FIFO holds {0x3, 0xA, 0xB, 0xC}, m_tready=1 → m_tdata 0xA, 0xB, 0xC on 3 consecutive cycles starting 2 cycles after the first pop. m_tlast only with 0xC. pkt_count=1. fifo_ren high for exactly 4 cycles.
- Back-pressure: header 0x4 with payload 1..4, m_tready=0 for 10 cycles, then 1 → exactly 2 payload pops, m_tdata held at 1. After release, 1..4 arrive in order, no loss or duplication, pkt_count=1.
- Zero-length and header masking: FIFO {0x0, 0xFFFF0001, 0x55} → zero_len=1 and no output for the 0x0 header. Single output 0x55 with m_tlast=1 (length=1 from the low 16 bits).
- Starved FIFO: fifo_rvalid toggles every cycle across a 5-word packet → fifo_ren never high while fifo_rvalid=0. Output order is correct; m_tlast is on word 5 only.
- Reset mid-packet: rst pulsed after 2 of 6 payload words → all outputs return to reset values the next cycle. The next FIFO word is parsed as a header.
- Back-to-back packets: 3 packets of lengths 1, 2, 1 with m_tready=1 → 4 outputs, m_tlast on words 1, 3, 4, pkt_count=3.
